// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: shared FIFO controller constants and the pointer type.
// Holds the default array address width, the pointer width (address plus wrap bit),
// the array depth and the pointer typedef.
package fifo_ctrl_pkg;
  localparam int ADDR_W = 9;
  localparam int PTR_W = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;
  typedef logic [PTR_W-1:0] ptr_t;
endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrapping pointer counter with async reset, sync clear and increment enable.
// Ports: clk, rst (async, active-high), clr (sync clear to 0), inc (advance by one),
// ptr (W-bit pointer, wraps naturally at 2^W).
module fifo_ptr
  import fifo_ctrl_pkg::*;
#(
  parameter int W = PTR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);
  logic [W-1:0] r_ptr;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_ptr <= '0;
    else     r_ptr <= clr ? '0 : r_ptr + W'(inc);
  assign ptr = r_ptr;
endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer and status controller for the 512 x 32 FIFO array.
// Ports: clk, rst (async, active-high), wr/rd requests, flush (sync clear);
// fifo_we/fifo_rd array enables, wptr/rptr (wrap bit + address), fifo_count,
// full/empty, almost_full/almost_empty, overflow/underflow error flags, rd_valid.
// Macro FIFO_CTRL_STICKY_ERR_EN: when defined, overflow/underflow hold until flush or
// rst; otherwise each is a one-cycle pulse in the cycle after the event.
module fifo_ctrl #(
  parameter int          ADDR_W   = fifo_ctrl_pkg::ADDR_W,
  parameter int unsigned AF_LEVEL = 480,
  parameter int unsigned AE_LEVEL = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr,
  input  logic            rd,
  input  logic            flush,
  output logic            fifo_we,
  output logic            fifo_rd,
  output logic [ADDR_W:0] wptr,
  output logic [ADDR_W:0] rptr,
  output logic            fifo_full,
  output logic            fifo_empty,
  output logic            fifo_almost_full,
  output logic            fifo_almost_empty,
  output logic            fifo_overflow,
  output logic            fifo_underflow,
  output logic [ADDR_W:0] fifo_count,
  output logic            rd_valid
);
  logic w_ovf_ev, w_udf_ev;
  logic r_ovf, r_udf, r_rd_valid;

  fifo_ptr #(.W(ADDR_W + 1)) u_wptr (.clk(clk), .rst(rst), .clr(flush), .inc(fifo_we), .ptr(wptr));
  fifo_ptr #(.W(ADDR_W + 1)) u_rptr (.clk(clk), .rst(rst), .clr(flush), .inc(fifo_rd), .ptr(rptr));

  // Full when the wrap bits differ but the array addresses coincide.
  assign fifo_empty = wptr == rptr;
  assign fifo_full = (wptr[ADDR_W] != rptr[ADDR_W]) && (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
  assign fifo_count = wptr - rptr;
  assign fifo_almost_full = 32'(fifo_count) >= AF_LEVEL;
  assign fifo_almost_empty = 32'(fifo_count) <= AE_LEVEL;
  assign fifo_we = wr & ~fifo_full & ~flush;
  assign fifo_rd = rd & ~fifo_empty & ~flush;
  assign w_ovf_ev = wr & fifo_full & ~flush;
  assign w_udf_ev = rd & fifo_empty & ~flush;

  // Events already exclude flush, so the pulse form clears on flush without extra logic.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
`ifdef FIFO_CTRL_STICKY_ERR_EN
      r_ovf <= ~flush & (r_ovf | w_ovf_ev);
      r_udf <= ~flush & (r_udf | w_udf_ev);
`else
      r_ovf <= w_ovf_ev;
      r_udf <= w_udf_ev;
`endif
      r_rd_valid <= fifo_rd;
    end

  assign fifo_overflow = r_ovf;
  assign fifo_underflow = r_udf;
  assign rd_valid = r_rd_valid;
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: randomized and directed bench for fifo_ctrl against an occupancy model.
module tb_fifo_ctrl;
  localparam int DEPTH = 512;
  localparam int PMOD = 1024;
  logic clk = 0, rst = 1, wr = 0, rd = 0, flush = 0;
  logic fifo_we, fifo_rd, fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty;
  logic fifo_overflow, fifo_underflow, rd_valid;
  logic [9:0] wptr, rptr, fifo_count;
  int total = 0, bad = 0;
  int m_w = 0, m_r = 0, m_cnt = 0, m_ovf = 0, m_udf = 0, m_rv = 0;

  fifo_ctrl dut (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .flush(flush),
    .fifo_we(fifo_we), .fifo_rd(fifo_rd), .wptr(wptr), .rptr(rptr),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_almost_full(fifo_almost_full), .fifo_almost_empty(fifo_almost_empty),
    .fifo_overflow(fifo_overflow), .fifo_underflow(fifo_underflow),
    .fifo_count(fifo_count), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic chk_state();
    chk("wptr", int'(wptr), m_w);
    chk("rptr", int'(rptr), m_r);
    chk("count", int'(fifo_count), m_cnt);
    chk("empty", int'(fifo_empty), int'(m_cnt == 0));
    chk("full", int'(fifo_full), int'(m_cnt == DEPTH));
    chk("almost_full", int'(fifo_almost_full), int'(m_cnt >= 480));
    chk("almost_empty", int'(fifo_almost_empty), int'(m_cnt <= 32));
    chk("overflow", int'(fifo_overflow), m_ovf);
    chk("underflow", int'(fifo_underflow), m_udf);
    chk("rd_valid", int'(rd_valid), m_rv);
  endtask

  task automatic model_reset();
    m_w = 0; m_r = 0; m_cnt = 0; m_ovf = 0; m_udf = 0; m_rv = 0;
  endtask

  // One clock: check zero-cycle enables, then the registered state after the edge.
  task automatic step(input bit w, input bit r, input bit f);
    bit ewe, ere, eov, eud;
    wr = w; rd = r; flush = f;
    #1;
    ewe = w && m_cnt < DEPTH && !f;
    ere = r && m_cnt > 0 && !f;
    eov = w && m_cnt == DEPTH && !f;
    eud = r && m_cnt == 0 && !f;
    chk("fifo_we", int'(fifo_we), int'(ewe));
    chk("fifo_rd", int'(fifo_rd), int'(ere));
    @(posedge clk);
    if (f) model_reset();
    else begin
      m_w = (m_w + int'(ewe)) % PMOD;
      m_r = (m_r + int'(ere)) % PMOD;
      m_cnt = m_cnt + int'(ewe) - int'(ere);
      m_rv = int'(ere);
`ifdef FIFO_CTRL_STICKY_ERR_EN
      m_ovf = m_ovf | int'(eov);
      m_udf = m_udf | int'(eud);
`else
      m_ovf = int'(eov);
      m_udf = int'(eud);
`endif
    end
    #1;
    chk_state();
  endtask

  initial begin
    #2;
    chk("rst_empty", int'(fifo_empty), 1);
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_we", int'(fifo_we), 0);
    @(posedge clk); #1;
    rst = 0;
    step(0, 0, 0);
    // fill to full, then one extra write
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0);
    chk("wptr_at_full", int'(wptr), 'h200);
    chk("full_after_512", int'(fifo_full), 1);
    step(1, 0, 0);
    chk("ovf_513", int'(fifo_overflow), 1);
    chk("wptr_hold", int'(wptr), 'h200);
    // drain, then one extra read
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0);
    step(0, 0, 0);
    chk("empty_after_drain", int'(fifo_empty), 1);
    step(0, 1, 0);
    chk("udf_extra", int'(fifo_underflow), 1);
    // wrap: occupancy held at 3 across pointer wrap
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      step(1, 1, 0);
      chk("diff3", int'((wptr - rptr) & 10'h3ff), 3);
    end
    // simultaneous at count 100
    step(0, 0, 1);
    for (int i = 0; i < 100; i++) step(1, 0, 0);
    step(1, 1, 0);
    chk("count100", int'(fifo_count), 100);
    // simultaneous when empty
    step(0, 0, 1);
    step(1, 1, 0);
    chk("empty_wr_ok", int'(fifo_count), 1);
    chk("empty_udf", int'(fifo_underflow), 1);
    // simultaneous when full
    for (int i = 0; i < DEPTH - 1; i++) step(1, 0, 0);
    step(1, 1, 0);
    chk("full_rd_ok", int'(fifo_count), DEPTH - 1);
    chk("full_ovf", int'(fifo_overflow), 1);
    // flush at count 200 with wr high
    step(0, 0, 1);
    for (int i = 0; i < 200; i++) step(1, 0, 0);
    step(1, 0, 1);
    chk("flush_wptr", int'(wptr), 0);
    chk("flush_empty", int'(fifo_empty), 1);
    // randomized traffic with occasional flush
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, $urandom_range(0, 199) == 0);
    // async reset mid-burst, checked before any clock edge
    for (int i = 0; i < 20; i++) step(1, i % 3 == 0, 0);
    rst = 1;
    #1;
    model_reset();
    chk_state();
    chk("arst_we", int'(fifo_we), 1);
    #1;
    rst = 0; wr = 0;
    step(0, 0, 0);
    step(1, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Pointer and status controller for the 512 x 32 FIFO memory array. Accepts write/read requests from the producer and consumer, gates them against full/empty, and drives the array's `fifo_we`, `fifo_rd`, `wptr` and `rptr`. It also generates occupancy, threshold and error flags, plus a read-data-valid strobe that matches the array's one-cycle registered read.

## Interface
Parameters:
- `ADDR_W`, default 9: array address width. Depth is 2^ADDR_W = 512.
- `AF_LEVEL`, default 480: `fifo_almost_full` asserts when count >= AF_LEVEL.
- `AE_LEVEL`, default 32: `fifo_almost_empty` asserts when count <= AE_LEVEL.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr`  in  1  producer write request; data is presented to the array alongside it.
- `rd`  in  1  consumer read request.
- `flush`  in  1  synchronous clear of the FIFO contents and status.
- `fifo_we`  out  1  write enable to the array.
- `fifo_rd`  out  1  read enable to the array.
- `wptr`  out  ADDR_W+1  write pointer; MSB is the wrap bit, low ADDR_W bits address the array.
- `rptr`  out  ADDR_W+1  read pointer, same format as `wptr`.
- `fifo_full`, `fifo_empty`  out  1  occupancy flags.
- `fifo_almost_full`, `fifo_almost_empty`  out  1  threshold flags.
- `fifo_overflow`, `fifo_underflow`  out  1  error flags.
- `fifo_count`  out  ADDR_W+1  number of stored words, 0..512.
- `rd_valid`  out  1  array `data_out` is valid this cycle.

## Operation
- `fifo_we = wr & ~fifo_full & ~flush`. `fifo_rd = rd & ~fifo_empty & ~flush`. Both are combinational from registered state.
- `wptr` increments modulo 2^(ADDR_W+1) on each `fifo_we`. `rptr` does the same on each `fifo_rd`. Wrap from 1023 to 0 is natural.
- Empty: `wptr == rptr`.
- Full: MSBs differ and low ADDR_W bits are equal.
- `fifo_count = wptr - rptr` in ADDR_W+1-bit modular arithmetic. No saturation is needed: the value never exceeds 512.
- Almost flags are combinational from `fifo_count` against the parameters.
- Simultaneous `wr` and `rd`:
  - Partial FIFO: both proceed and the count is unchanged.
  - Full FIFO: the read proceeds and the write is blocked and flagged as overflow.
  - Empty FIFO: the write proceeds and the read is blocked and flagged as underflow.
- Overflow event: `wr & fifo_full & ~flush`. Underflow event: `rd & fifo_empty & ~flush`.
- `rd_valid` is registered from `fifo_rd`, one cycle late, to match the array's registered `data_out`.
- `flush` high at a clock edge has the following effect at that edge:
  - both pointers go to 0;
  - `rd_valid` goes to 0;
  - error flags clear;
  - requests in the same cycle are ignored: no enable and no error.
  - Flush takes priority over everything except `rst`.
- Reset values: `wptr = rptr = 0`, so `fifo_empty = 1`, `fifo_almost_empty = 1`, `fifo_full = 0`, `fifo_almost_full = 0` and `fifo_count = 0`. `fifo_overflow`, `fifo_underflow` and `rd_valid` are 0. `fifo_we` and `fifo_rd` are 0 unless `wr` is asserted.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge. Contents of the array are abandoned.

## Timing
- Enables: zero-cycle. `fifo_we` and `fifo_rd` follow the requests in the same cycle.
- Pointers, count and all flags: updated at the edge that consumes the enable, and visible in the following cycle.
- Read latency: `fifo_rd` in cycle N gives `rd_valid` and valid array data in cycle N+1.
- Write-to-read: a word written in cycle N is readable (`fifo_empty` = 0) in cycle N+1.
- No handshake back-pressure beyond the flags. The requester must sample `fifo_full` or `fifo_empty`; blocked requests are dropped, not queued.

## Configuration
- `FIFO_CTRL_STICKY_ERR_EN` defined: `fifo_overflow` and `fifo_underflow` are sticky. They are set by the event and held until `flush` or `rst`.
- Not defined: each flag is a registered single-cycle pulse, high in the cycle after each event, and is also cleared by `flush`.

## Structure
- Shared package `fifo_ctrl_pkg` holds `ADDR_W`, `PTR_W = ADDR_W+1`, `DEPTH = 1 << ADDR_W`, and a `ptr_t` typedef of PTR_W bits.
- One sub-module, `fifo_ptr`. It is a PTR_W-bit wrapping counter with async reset, a synchronous clear and an increment enable. It is instantiated twice, once for write and once for read.
- Status and flag logic lives in `fifo_ctrl`.

## Test plan
- Reset, then idle: `fifo_empty` = 1, `fifo_count` = 0, `wptr` = `rptr` = 0, no enables.
- 512 consecutive writes: `fifo_full` = 1 and `wptr` = 0x200, `fifo_almost_full` first high after write 480. A 513th `wr` gives `fifo_we` = 0 and overflow set; `wptr` stays at 0x200.
- From full, 512 reads: `rd_valid` is high for 512 cycles, each one cycle after `fifo_rd`, and `fifo_empty` = 1 at the end. A further `rd` gives `fifo_rd` = 0 and underflow.
- Wrap check: run 1500 write/read pairs with occupancy held at 3. `wptr - rptr` = 3 throughout, and pointers cross 1023 to 0 with no false `fifo_full` or `fifo_empty`.
- Simultaneous `wr` and `rd`:
  - at count 100: count stays 100;
  - when empty: write accepted and underflow flagged;
  - when full: read accepted and overflow flagged.
- Flush at count 200 with `wr` high: pointers 0, `fifo_empty` = 1, no `fifo_we`, errors cleared. Separately, `rst` pulsed asynchronously mid-burst clears all state without a clock edge.
